rrv2rvh_ruby_req_adapter: RTL and testbench
===========================================

// Module: rrv2rvh_ruby_req_adapter
// PURPOSE
//  Multi-channel Ruby->RVH L1D request adapter. Decodes each channel's 6-bit rrv64 Ruby
//  request type into the RVH LDU/STU op encoding at enqueue time and buffers it in a
//  per-channel FIFO. A round-robin arbiter merges all channels onto one valid/ready port
//  toward the L1D. Illegal types are dropped and reported.
// PARAMETERS
//  NUM_CH      2   request channels (1..8)
//  FIFO_DEPTH  4   entries per channel FIFO (power of 2, >=2)
//  ADDR_W      40  request address width
//  TAG_W       8   request tag width
//  DATA_W      64  store data width
// PORTS
//  clk             in   1                  clock
//  rst             in   1                  async reset, active-low
//  flush_i         in   1                  sync flush of all FIFOs and arbiter
//  in_valid_i      in   NUM_CH             per-channel request valid
//  in_ready_o      out  NUM_CH             per-channel ready (= !full & !flush_i)
//  in_type_i       in   NUM_CH*6           rrv64 Ruby req type, channel c at [6c+:6]
//  in_addr_i       in   NUM_CH*ADDR_W      address
//  in_tag_i        in   NUM_CH*TAG_W       tag
//  in_data_i       in   NUM_CH*DATA_W      store data
//  out_valid_o     out  1                  translated request valid
//  out_ready_i     in   1                  L1D accepts
//  out_is_ld_o     out  1                  1 = load, 0 = store
//  out_ld_op_o     out  3                  LDU op (0 when store)
//  out_st_op_o     out  5                  STU op (0 when load)
//  out_addr_o / out_tag_o / out_data_o  out  ADDR_W / TAG_W / DATA_W  payload
//  out_ch_o        out  max(1,$clog2(NUM_CH))  source channel
//  err_valid_o     out  1                  one-cycle pulse: illegal type dropped
//  err_ch_o        out  max(1,$clog2(NUM_CH))  channel of the dropped request
//  err_type_o      out  6                  offending type
//  err_cnt_o       out  16                 saturating count of dropped requests
// BEHAVIOUR
//  Decode (type -> op): loads: 1->0 2->3 3->1 4->4 5->2 6->5 7->6 34->2 36->6.
//   stores: 0->0; 8..11 -> 0..3; 12..33 -> type-5 (7..28); 35->2 37->3 38->4.
//   types 39..63 illegal. Unused op field driven 0.
//  Enqueue: channel c accepted when in_valid_i[c] & in_ready_o[c]. Legal -> decoded entry
//   written into FIFO c. Illegal -> no write; err_* registered next cycle.
//  Two illegal accepts in one cycle: lowest channel index reported on err_ch_o/err_type_o;
//   err_cnt_o adds the number of illegal accepts, saturating at 16'hFFFF.
//  Latency: an accept in cycle N is visible on out_* no earlier than cycle N+1. No bypass.
//  Full FIFO: in_ready_o[c]=0; simultaneous dequeue does not re-open ready in that cycle.
//  Simultaneous enq+deq on one FIFO: count unchanged; pointers wrap mod FIFO_DEPTH.
//  Output/arbitration:
//   - out_valid_o = any FIFO non-empty.
//   - Payload is the head of the granted channel: first non-empty at or after rr_ptr.
//   - On out_valid_o & out_ready_i: pop that head; rr_ptr <= granted+1 (mod NUM_CH).
//   - With out_ready_i=0, grant and payload hold stable; a new request arriving on
//     another channel does not change them.
//  flush_i: next cycle all FIFOs empty, rr_ptr=0, err_valid_o=0. in_ready_o=0 during the
//   flush cycle. err_cnt_o is preserved.
//  Reset (rst=0, async): FIFOs empty, rr_ptr=0, out_valid_o=0, err_valid_o=0,
//   err_ch_o=0, err_type_o=0, err_cnt_o=0. in_ready_o is all ones once FIFOs are empty.
//   Reset mid-transfer discards all buffered entries.
// TESTING
//  1. ch0 type 2 addr 0x100 tag 5, out_ready=1 -> next cycle out_is_ld=1 ld_op=3 st_op=0
//     ch=0; type 12 -> is_ld=0 st_op=7.
//  2. Sweep types 0..38 on ch1 -> every decode matches the table; types 39 and 63 ->
//     no out_valid; err_valid pulse with ch=1 and type=39/63; err_cnt=2.
//  3. NUM_CH=2, both channels stream 8 reqs, out_ready=1 -> outputs alternate 0,1,0,1...
//     with each channel's order preserved.
//  4. out_ready=0, ch0 sends 5 reqs (DEPTH=4) -> 4 accepted, in_ready[0]=0 at count 4;
//     release -> tags drain in order.
//  5. Hold out_ready=0 with grant on ch1, then push ch0 -> payload stays ch1 until
//     accepted.
//  6. Fill both FIFOs, pulse flush_i -> next cycle out_valid=0, rr_ptr=0, err_cnt kept.
//     Assert rst mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rrv2rvh_ruby_req_adapter.sv
// Ruby->RVH L1D request adapter: decodes rrv64 Ruby request types into LDU/STU ops,
// buffers them per channel and merges all channels round-robin onto one port.
module rrv2rvh_ruby_req_adapter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 40,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned DATA_W     = 64,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_CH-1:0]          in_valid_i,
  output logic [NUM_CH-1:0]          in_ready_o,
  input  logic [NUM_CH*6-1:0]        in_type_i,
  input  logic [NUM_CH*ADDR_W-1:0]   in_addr_i,
  input  logic [NUM_CH*TAG_W-1:0]    in_tag_i,
  input  logic [NUM_CH*DATA_W-1:0]   in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_is_ld_o,
  output logic [2:0]                 out_ld_op_o,
  output logic [4:0]                 out_st_op_o,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic [TAG_W-1:0]           out_tag_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [CH_W-1:0]            out_ch_o,
  output logic                       err_valid_o,
  output logic [CH_W-1:0]            err_ch_o,
  output logic [5:0]                 err_type_o,
  output logic [15:0]                err_cnt_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ERRN_W = $clog2(NUM_CH + 1);

  typedef struct packed {
    logic       legal;
    logic       is_ld;
    logic [2:0] ld_op;
    logic [4:0] st_op;
  } dec_t;

  typedef struct packed {
    logic              is_ld;
    logic [2:0]        ld_op;
    logic [4:0]        st_op;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Ruby request type -> LDU/STU op; the op field of the other unit stays 0
  function automatic dec_t decode(input logic [5:0] t);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (t) inside
      6'd1:          begin d.is_ld = 1'b1; d.ld_op = 3'd0; end
      6'd2:          begin d.is_ld = 1'b1; d.ld_op = 3'd3; end
      6'd3:          begin d.is_ld = 1'b1; d.ld_op = 3'd1; end
      6'd4:          begin d.is_ld = 1'b1; d.ld_op = 3'd4; end
      6'd5:          begin d.is_ld = 1'b1; d.ld_op = 3'd2; end
      6'd6:          begin d.is_ld = 1'b1; d.ld_op = 3'd5; end
      6'd7:          begin d.is_ld = 1'b1; d.ld_op = 3'd6; end
      6'd34:         begin d.is_ld = 1'b1; d.ld_op = 3'd2; end
      6'd36:         begin d.is_ld = 1'b1; d.ld_op = 3'd6; end
      6'd0:          d.st_op = 5'd0;
      [6'd8:6'd11]:  d.st_op = 5'(t - 6'd8);
      [6'd12:6'd33]: d.st_op = 5'(t - 6'd5);
      6'd35:         d.st_op = 5'd2;
      6'd37:         d.st_op = 5'd3;
      6'd38:         d.st_op = 5'd4;
      default:       d.legal = 1'b0;
    endcase
    return d;
  endfunction

  entry_t            mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  dec_t              dec    [NUM_CH];
  entry_t            wdata  [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_grant;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   grant_inc;
  logic [CH_W-1:0]   lock_ch;
  logic              lock;
  logic              handshake;
  entry_t            head;

  logic              err_any;
  logic [CH_W-1:0]   err_ch_c;
  logic [5:0]        err_type_c;
  logic [ERRN_W-1:0] err_n;
  logic [16:0]       err_sum;
  logic [15:0]       err_cnt_next;

  // Per-channel FIFO status and enqueue-time decode
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      full[c]        = (count[c] == CNT_W'(FIFO_DEPTH));
      nonempty[c]    = (count[c] != '0);
      dec[c]         = decode(in_type_i[6*c +: 6]);
      wdata[c].is_ld = dec[c].is_ld;
      wdata[c].ld_op = dec[c].ld_op;
      wdata[c].st_op = dec[c].st_op;
      wdata[c].addr  = in_addr_i[ADDR_W*c +: ADDR_W];
      wdata[c].tag   = in_tag_i[TAG_W*c +: TAG_W];
      wdata[c].data  = in_data_i[DATA_W*c +: DATA_W];
      push[c]        = acc[c] & dec[c].legal;
      pop[c]         = handshake && (grant == CH_W'(c));
    end
  end

  assign in_ready_o = ~full & {NUM_CH{~flush_i}};
  assign acc        = in_valid_i & in_ready_o;

  // First non-empty channel at or after rr_ptr
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = (int'(rr_ptr) + i) % int'(NUM_CH);
      if (!found && nonempty[idx]) begin
        found    = 1'b1;
        rr_grant = CH_W'(idx);
      end
    end
  end

  // A stalled grant is locked so late arrivals cannot steal the output
  assign grant     = lock ? lock_ch : rr_grant;
  assign grant_inc = (grant == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(grant + CH_W'(1));
  assign head      = mem[grant][rd_ptr[grant]];

  assign out_valid_o = |nonempty;
  assign handshake   = out_valid_o & out_ready_i;
  assign out_is_ld_o = head.is_ld;
  assign out_ld_op_o = head.ld_op;
  assign out_st_op_o = head.st_op;
  assign out_addr_o  = head.addr;
  assign out_tag_o   = head.tag;
  assign out_data_o  = head.data;
  assign out_ch_o    = grant;

  // Illegal-type reporting: lowest channel wins, count adds all drops
  always_comb begin
    err_any    = 1'b0;
    err_ch_c   = '0;
    err_type_c = '0;
    err_n      = '0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (acc[c] && !dec[c].legal) begin
        err_any    = 1'b1;
        err_ch_c   = CH_W'(c);
        err_type_c = in_type_i[6*c +: 6];
        err_n      = err_n + ERRN_W'(1);
      end
    end
    err_sum      = 17'(err_cnt_o) + 17'(err_n);
    err_cnt_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Storage array carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= wdata[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      rr_ptr      <= '0;
      lock        <= 1'b0;
      lock_ch     <= '0;
      err_valid_o <= 1'b0;
      err_ch_o    <= '0;
      err_type_o  <= '0;
      err_cnt_o   <= '0;
    end else if (flush_i) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      rr_ptr      <= '0;
      lock        <= 1'b0;
      lock_ch     <= '0;
      err_valid_o <= 1'b0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (push[c] && !pop[c])      count[c] <= count[c] + CNT_W'(1);
        else if (!push[c] && pop[c]) count[c] <= count[c] - CNT_W'(1);
      end
      if (handshake) rr_ptr <= grant_inc;
      if (out_valid_o && !out_ready_i) begin
        lock    <= 1'b1;
        lock_ch <= grant;
      end else begin
        lock    <= 1'b0;
      end
      err_valid_o <= err_any;
      if (err_any) begin
        err_ch_o   <= err_ch_c;
        err_type_o <= err_type_c;
        err_cnt_o  <= err_cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_rrv2rvh_ruby_req_adapter.sv
// Self-checking bench for rrv2rvh_ruby_req_adapter: decode table sweep, arbitration,
// back-pressure, flush and reset, with a per-channel scoreboard.
module tb_rrv2rvh_ruby_req_adapter;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W     = 40;
  localparam int unsigned TAG_W      = 8;
  localparam int unsigned DATA_W     = 64;

  logic                     clk;
  logic                     rst;
  logic                     flush_i;
  logic [NUM_CH-1:0]        in_valid_i;
  logic [NUM_CH-1:0]        in_ready_o;
  logic [NUM_CH*6-1:0]      in_type_i;
  logic [NUM_CH*ADDR_W-1:0] in_addr_i;
  logic [NUM_CH*TAG_W-1:0]  in_tag_i;
  logic [NUM_CH*DATA_W-1:0] in_data_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic                     out_is_ld_o;
  logic [2:0]               out_ld_op_o;
  logic [4:0]               out_st_op_o;
  logic [ADDR_W-1:0]        out_addr_o;
  logic [TAG_W-1:0]         out_tag_o;
  logic [DATA_W-1:0]        out_data_o;
  logic [0:0]               out_ch_o;
  logic                     err_valid_o;
  logic [0:0]               err_ch_o;
  logic [5:0]               err_type_o;
  logic [15:0]              err_cnt_o;

  rrv2rvh_ruby_req_adapter #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_type_i(in_type_i),
    .in_addr_i(in_addr_i), .in_tag_i(in_tag_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_is_ld_o(out_is_ld_o),
    .out_ld_op_o(out_ld_op_o), .out_st_op_o(out_st_op_o), .out_addr_o(out_addr_o),
    .out_tag_o(out_tag_o), .out_data_o(out_data_o), .out_ch_o(out_ch_o),
    .err_valid_o(err_valid_o), .err_ch_o(err_ch_o), .err_type_o(err_type_o),
    .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    logic [5:0] typ;
    logic       legal;
    logic       is_ld;
    logic [2:0] ld_op;
    logic [4:0] st_op;
  } vec_t;

  typedef struct packed {
    logic              ch;
    logic              is_ld;
    logic [2:0]        ld_op;
    logic [4:0]        st_op;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct packed {
    logic        ch;
    logic [5:0]  typ;
    logic [15:0] cnt;
  } err_t;

  vec_t        vt [41];
  logic        lut_legal [64];
  logic        lut_is_ld [64];
  logic [2:0]  lut_ld    [64];
  logic [4:0]  lut_st    [64];

  exp_t        sbq  [$];
  err_t        errq [$];
  int          checks;
  int          errors;
  logic        mon_en;
  logic        alt_en;
  logic        alt_exp;
  logic [15:0] exp_err_cnt;
  int          hit;
  exp_t        me;
  err_t        mee;

  logic [5:0]        r_type [NUM_CH];
  logic [ADDR_W-1:0] r_addr [NUM_CH];
  logic [TAG_W-1:0]  r_tag  [NUM_CH];
  logic [DATA_W-1:0] r_data [NUM_CH];

  assign in_type_i = {r_type[1], r_type[0]};
  assign in_addr_i = {r_addr[1], r_addr[0]};
  assign in_tag_i  = {r_tag[1],  r_tag[0]};
  assign in_data_i = {r_data[1], r_data[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ld(input int t, input logic [2:0] op);
    vt[t].is_ld = 1'b1;
    vt[t].ld_op = op;
  endtask

  // Expected decode table, written out from the type->op list
  task automatic build_tables();
    for (int i = 0; i < 39; i++) vt[i] = '{typ: 6'(i), legal: 1'b1, is_ld: 1'b0, ld_op: 3'd0, st_op: 5'd0};
    for (int i = 8; i <= 11; i++)  vt[i].st_op = 5'(i - 8);
    for (int i = 12; i <= 33; i++) vt[i].st_op = 5'(i - 5);
    vt[35].st_op = 5'd2;
    vt[37].st_op = 5'd3;
    vt[38].st_op = 5'd4;
    set_ld(1, 3'd0); set_ld(2, 3'd3); set_ld(3, 3'd1); set_ld(4, 3'd4); set_ld(5, 3'd2);
    set_ld(6, 3'd5); set_ld(7, 3'd6); set_ld(34, 3'd2); set_ld(36, 3'd6);
    vt[39] = '{typ: 6'd39, legal: 1'b0, is_ld: 1'b0, ld_op: 3'd0, st_op: 5'd0};
    vt[40] = '{typ: 6'd63, legal: 1'b0, is_ld: 1'b0, ld_op: 3'd0, st_op: 5'd0};
    for (int t = 0; t < 64; t++) begin
      lut_legal[t] = 1'b0; lut_is_ld[t] = 1'b0; lut_ld[t] = 3'd0; lut_st[t] = 5'd0;
    end
    for (int i = 0; i < 41; i++) begin
      lut_legal[vt[i].typ] = vt[i].legal;
      lut_is_ld[vt[i].typ] = vt[i].is_ld;
      lut_ld[vt[i].typ]    = vt[i].ld_op;
      lut_st[vt[i].typ]    = vt[i].st_op;
    end
  endtask

  task automatic set_req(input int c, input logic [5:0] t, input logic [ADDR_W-1:0] a,
                         input logic [TAG_W-1:0] g);
    r_type[c] = t;
    r_addr[c] = a;
    r_tag[c]  = g;
    r_data[c] = {$urandom, $urandom};
  endtask

  // One bus cycle: drive valids, sample ready mid-cycle, record accepted requests
  task automatic cycle(input logic [NUM_CH-1:0] v, output logic [NUM_CH-1:0] acc, output logic ov);
    exp_t e;
    err_t er;
    logic got;
    in_valid_i = v;
    @(negedge clk);
    acc = v & in_ready_o;
    ov  = out_valid_o;
    @(posedge clk);
    got = 1'b0;
    er  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (acc[c]) begin
        if (lut_legal[r_type[c]]) begin
          e.ch    = 1'(c);
          e.is_ld = lut_is_ld[r_type[c]];
          e.ld_op = lut_ld[r_type[c]];
          e.st_op = lut_st[r_type[c]];
          e.addr  = r_addr[c];
          e.tag   = r_tag[c];
          e.data  = r_data[c];
          sbq.push_back(e);
        end else begin
          if (exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
          if (!got) begin
            er.ch  = 1'(c);
            er.typ = r_type[c];
          end
          got = 1'b1;
        end
      end
    end
    if (got) begin
      er.cnt = exp_err_cnt;
      errq.push_back(er);
    end
    #1;
    in_valid_i = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && (sbq.size() != 0 || errq.size() != 0); k++) @(posedge clk);
    #1;
    chk({name, "_sb_left"}, 64'(sbq.size()), 64'd0);
    chk({name, "_err_left"}, 64'(errq.size()), 64'd0);
  endtask

  // Both channels push n requests each, holding each one until accepted
  task automatic stream(input int n, input logic [7:0] tag_base, output int total);
    int kk [NUM_CH];
    logic [NUM_CH-1:0] v;
    logic [NUM_CH-1:0] a;
    logic ov;
    kk[0] = 0; kk[1] = 0;
    for (int g = 0; g < 100 && (kk[0] < n || kk[1] < n); g++) begin
      v = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (kk[c] < n) begin
          v[c] = 1'b1;
          set_req(c, (c == 0) ? 6'(1 + kk[c] % 7) : 6'(12 + kk[c]),
                  40'h1000 + 40'(c * 256 + kk[c]), tag_base + 8'(c * 16 + kk[c]));
        end
      end
      cycle(v, a, ov);
      for (int c = 0; c < int'(NUM_CH); c++) if (a[c]) kk[c]++;
    end
    total = kk[0] + kk[1];
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (out_valid_o && out_ready_i) begin
        hit = -1;
        for (int i = 0; i < sbq.size(); i++) if (hit < 0 && sbq[i].ch == out_ch_o) hit = i;
        if (hit < 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got ch %0d tag %0h expected no output", out_ch_o, out_tag_o);
        end else begin
          me = sbq[hit];
          sbq.delete(hit);
          chk("out_is_ld", 64'(out_is_ld_o), 64'(me.is_ld));
          chk("out_ld_op", 64'(out_ld_op_o), 64'(me.ld_op));
          chk("out_st_op", 64'(out_st_op_o), 64'(me.st_op));
          chk("out_addr",  64'(out_addr_o),  64'(me.addr));
          chk("out_tag",   64'(out_tag_o),   64'(me.tag));
          chk("out_data",  out_data_o,       me.data);
        end
        if (alt_en) begin
          chk("t3_alternate", 64'(out_ch_o), 64'(alt_exp));
          alt_exp = ~alt_exp;
        end
      end
      if (err_valid_o) begin
        if (errq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected: got type %0d ch %0d expected no error", err_type_o, err_ch_o);
        end else begin
          mee = errq.pop_front();
          chk("err_ch",   64'(err_ch_o),   64'(mee.ch));
          chk("err_type", 64'(err_type_o), 64'(mee.typ));
          chk("err_cnt",  64'(err_cnt_o),  64'(mee.cnt));
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] acc;
    logic ov;
    int total;
    checks = 0; errors = 0; mon_en = 1'b0; alt_en = 1'b0; alt_exp = 1'b0;
    exp_err_cnt = '0;
    build_tables();
    for (int c = 0; c < int'(NUM_CH); c++) set_req(c, 6'd0, '0, '0);
    flush_i = 1'b0; in_valid_i = '0; out_ready_i = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_err_valid", 64'(err_valid_o), 64'd0);
    chk("rst_err_cnt",   64'(err_cnt_o),   64'd0);
    chk("rst_in_ready",  64'(in_ready_o),  64'd3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic load and store translation, no same-cycle bypass
    out_ready_i = 1'b1;
    set_req(0, 6'd2, 40'h100, 8'd5);
    cycle(2'b01, acc, ov);
    chk("t1_accept", 64'(acc), 64'd1);
    chk("t1_no_bypass", 64'(ov), 64'd0);
    @(negedge clk);
    chk("t1_ld_valid", 64'(out_valid_o), 64'd1);
    chk("t1_ld_is_ld", 64'(out_is_ld_o), 64'd1);
    chk("t1_ld_op",    64'(out_ld_op_o), 64'd3);
    chk("t1_ld_st_op", 64'(out_st_op_o), 64'd0);
    chk("t1_ld_ch",    64'(out_ch_o),    64'd0);
    @(posedge clk); #1;
    set_req(0, 6'd12, 40'h108, 8'd6);
    cycle(2'b01, acc, ov);
    @(negedge clk);
    chk("t1_st_is_ld", 64'(out_is_ld_o), 64'd0);
    chk("t1_st_op",    64'(out_st_op_o), 64'd7);
    @(posedge clk); #1;
    wait_drain("t1");

    // Full type sweep on ch1 from the vector table, incl. illegal 39 and 63
    for (int i = 0; i < 41; i++) begin
      set_req(1, vt[i].typ, 40'h2000 + 40'(i), 8'(i));
      cycle(2'b10, acc, ov);
      chk("t2_accept", 64'(acc[1]), 64'd1);
    end
    wait_drain("t2");
    chk("t2_err_cnt", 64'(err_cnt_o), 64'd2);

    // Two streaming channels alternate on the output
    alt_en = 1'b1; alt_exp = 1'b0;
    stream(8, 8'h20, total);
    chk("t3_pushed", 64'(total), 64'd16);
    wait_drain("t3");
    alt_en = 1'b0;

    // Back-pressure: fifth request refused, drain order kept
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 6'd3, 40'h3000 + 40'(k), 8'h40 + 8'(k));
      cycle(2'b01, acc, ov);
      chk("t4_accept", 64'(acc[0]), (k < 4) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    chk("t4_full_ready", 64'(in_ready_o[0]), 64'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_deq_no_reopen", 64'(in_ready_o[0]), 64'd0);
    wait_drain("t4");

    // Stalled grant on ch1 holds against a later ch0 request
    set_req(1, 6'd8, 40'h4000, 8'h50);
    cycle(2'b10, acc, ov);
    wait_drain("t5a");
    out_ready_i = 1'b0;
    set_req(1, 6'd9, 40'h4008, 8'h51);
    cycle(2'b10, acc, ov);
    set_req(0, 6'd1, 40'h4010, 8'h52);
    cycle(2'b01, acc, ov);
    chk("t5_ch0_accept", 64'(acc), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_ch",  64'(out_ch_o),  64'd1);
      chk("t5_hold_tag", 64'(out_tag_o), 64'h51);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    wait_drain("t5");

    // Flush: everything dropped, ready low during flush, rr pointer back to 0
    out_ready_i = 1'b0;
    stream(4, 8'h60, total);
    chk("t6_filled", 64'(total), 64'd8);
    flush_i = 1'b1;
    cycle(2'b11, acc, ov);
    chk("t6_flush_ready", 64'(acc), 64'd0);
    flush_i = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("t6_out_valid", 64'(out_valid_o), 64'd0);
    chk("t6_err_valid", 64'(err_valid_o), 64'd0);
    chk("t6_err_cnt",   64'(err_cnt_o),   64'd2);
    chk("t6_in_ready",  64'(in_ready_o),  64'd3);
    @(posedge clk); #1;
    set_req(0, 6'd5, 40'h5000, 8'h70);
    set_req(1, 6'd20, 40'h5008, 8'h71);
    cycle(2'b11, acc, ov);
    @(negedge clk);
    chk("t6_rr_ptr0", 64'(out_ch_o), 64'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    wait_drain("t6");

    // Asynchronous reset in the middle of traffic
    out_ready_i = 1'b0;
    stream(2, 8'h80, total);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t7_out_valid", 64'(out_valid_o), 64'd0);
    chk("t7_err_valid", 64'(err_valid_o), 64'd0);
    chk("t7_err_cnt",   64'(err_cnt_o),   64'd0);
    chk("t7_err_ch",    64'(err_ch_o),    64'd0);
    chk("t7_err_type",  64'(err_type_o),  64'd0);
    chk("t7_in_ready",  64'(in_ready_o),  64'd3);
    sbq.delete(); errq.delete(); exp_err_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Two illegal requests together: lowest channel reported, count +2
    out_ready_i = 1'b1;
    set_req(0, 6'd40, 40'h6000, 8'h90);
    set_req(1, 6'd50, 40'h6008, 8'h91);
    cycle(2'b11, acc, ov);
    set_req(1, 6'd38, 40'h6010, 8'h92);
    cycle(2'b10, acc, ov);
    wait_drain("t8");
    chk("t8_err_cnt", 64'(err_cnt_o), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
